// File: rtl/picorv32_sram_pkg.sv
// Shared types and constants for the picorv32 SRAM controller.
// Holds the FSM state encoding, the grant encoding, the control-register
// bit layout and a helper that assembles the control-register read value.
package picorv32_sram_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

    typedef enum logic [0:0] {
        GNT_CPU = 1'b0,
        GNT_WB  = 1'b1
    } gnt_t;

    // Bit positions of the requesters in the arbiter req/gnt vectors
    localparam int IDX_CPU = 0;
    localparam int IDX_WB  = 1;

    // Control register layout
    localparam int CTRL_RUN_BIT = 0;
    localparam int CTRL_ERR_BIT = 1;
    localparam int CTRL_AW_LSB  = 16;

    localparam logic [31:0] CTRL_OFFSET_DEFAULT = 32'h0001_0000;

    // Assemble the control-register read value; unlisted bits read as zero
    function automatic logic [31:0] ctrl_word(input logic run, input logic err,
                                              input logic [7:0] aw);
        logic [31:0] w;
        w = 32'h0000_0000;
        w[CTRL_RUN_BIT] = run;
        w[CTRL_ERR_BIT] = err;
        w[CTRL_AW_LSB +: 8] = aw;
        return w;
    endfunction

endpackage

// File: rtl/sram_rr_arb2.sv
// Two-input round-robin arbiter.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset (last grant returns to CPU)
//   req  - request vector, bit IDX_CPU = CPU, bit IDX_WB = Wishbone
//   gnt  - one-hot grant, combinational from req and the last-grant register
module sram_rr_arb2
    import picorv32_sram_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    gnt_t last_gnt_r;

    // Grant logic: a lone request wins outright, a tie goes to whoever was not served last
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last_gnt_r == GNT_CPU) ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

    // Last-grant register: records the most recently served requester
    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt_r <= GNT_CPU;
        end else if (gnt[IDX_WB]) begin
            last_gnt_r <= GNT_WB;
        end else if (gnt[IDX_CPU]) begin
            last_gnt_r <= GNT_CPU;
        end else begin
            last_gnt_r <= last_gnt_r;
        end
    end

endmodule

// File: rtl/picorv32_sram.sv
// picorv32_sram_ctrl: shares one single-port SRAM between a Wishbone slave
// port and a picorv32 native memory port, plus a control register that
// holds the core in reset (run) and flags out-of-range CPU accesses (err).
// Ports:
//   wb_clk_i / wb_rst_i        - clock, synchronous active-high reset
//   wbs_*                      - Wishbone slave request / response
//   cpu_mem_*                  - picorv32 native request / response
//   cpu_resetn                 - registered copy of ctrl.run, active-low core reset
//   ram_en0/we0/a0/di0, do0    - SRAM port, read data one cycle after enable
// Every access is granted in IDLE and answered in the following RESP cycle.
module picorv32_sram_ctrl
    import picorv32_sram_pkg::*;
#(
    parameter int unsigned ADDR_W      = 9,
    parameter logic [31:0] WB_BASE     = 32'h3000_0000,
    parameter logic [31:0] CTRL_OFFSET = CTRL_OFFSET_DEFAULT
)(
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_dat_i,
    input  logic [31:0]       wbs_adr_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    input  logic              cpu_mem_valid,
    input  logic [31:0]       cpu_mem_addr,
    input  logic [31:0]       cpu_mem_wdata,
    input  logic [3:0]        cpu_mem_wstrb,
    output logic              cpu_mem_ready,
    output logic [31:0]       cpu_mem_rdata,
    output logic              cpu_resetn,
    output logic              ram_en0,
    output logic [3:0]        ram_we0,
    output logic [ADDR_W-1:0] ram_a0,
    output logic [31:0]       ram_di0,
    input  logic [31:0]       ram_do0
);

    localparam logic [31:0] SRAM_BYTES = 32'd4 << ADDR_W;
    localparam logic [31:0] CTRL_ADDR  = WB_BASE + CTRL_OFFSET;

    state_t      state_r;
    state_t      state_nxt_s;
    logic        run_r;
    logic        err_r;
    logic        cpu_resetn_r;
    logic        resp_cpu_r;
    logic        resp_wb_r;
    logic        resp_sram_rd_r;
    logic [31:0] resp_reg_data_r;
    logic [1:0]  req_s;
    logic [1:0]  gnt_s;
    logic        cpu_in_range_s;
    logic [31:0] wb_off_s;
    logic        wb_in_sram_s;
    logic        wb_is_ctrl_s;
    logic        ctrl_wr_s;
    logic        cpu_oor_s;

    // Address decode for both requesters; the SRAM window takes priority over the ctrl word
    always_comb begin
        cpu_in_range_s = ((cpu_mem_addr >> (ADDR_W + 2)) == 32'h0000_0000);
        wb_off_s       = wbs_adr_i - WB_BASE;
        wb_in_sram_s   = (wbs_adr_i >= WB_BASE) && (wb_off_s < SRAM_BYTES);
        wb_is_ctrl_s   = ((wbs_adr_i >> 2) == (CTRL_ADDR >> 2)) && !wb_in_sram_s;
    end

    // Requests are only offered to the arbiter in IDLE and never while reset is held
    always_comb begin
        req_s = 2'b00;
        if ((state_r == ST_IDLE) && !wb_rst_i) begin
            req_s[IDX_CPU] = cpu_mem_valid & run_r;
            req_s[IDX_WB]  = wbs_stb_i & wbs_cyc_i;
        end else begin
            req_s = 2'b00;
        end
    end

    sram_rr_arb2 u_arb (
        .clk (wb_clk_i),
        .rst (wb_rst_i),
        .req (req_s),
        .gnt (gnt_s)
    );

    assign ctrl_wr_s = gnt_s[IDX_WB] & wb_is_ctrl_s & wbs_we_i & wbs_sel_i[0];
    assign cpu_oor_s = gnt_s[IDX_CPU] & ~cpu_in_range_s;

    // FSM state register
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state and SRAM port drive; the SRAM sees the granted request in the grant cycle
    always_comb begin
        state_nxt_s = state_r;
        ram_en0     = 1'b0;
        ram_we0     = 4'b0000;
        ram_a0      = {ADDR_W{1'b0}};
        ram_di0     = 32'h0000_0000;
        case (state_r)
            ST_IDLE: begin
                if (gnt_s != 2'b00) begin
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
                if (gnt_s[IDX_CPU] && cpu_in_range_s) begin
                    ram_en0 = 1'b1;
                    ram_we0 = cpu_mem_wstrb;
                    ram_a0  = cpu_mem_addr[ADDR_W+1:2];
                    ram_di0 = cpu_mem_wdata;
                end else if (gnt_s[IDX_WB] && wb_in_sram_s) begin
                    ram_en0 = 1'b1;
                    ram_we0 = wbs_we_i ? wbs_sel_i : 4'b0000;
                    ram_a0  = wb_off_s[ADDR_W+1:2];
                    ram_di0 = wbs_dat_i;
                end else begin
                    ram_en0 = 1'b0;
                end
            end
            ST_RESP: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Capture who owns the upcoming RESP cycle and where its data comes from
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            resp_cpu_r      <= 1'b0;
            resp_wb_r       <= 1'b0;
            resp_sram_rd_r  <= 1'b0;
            resp_reg_data_r <= 32'h0000_0000;
        end else begin
            resp_cpu_r      <= gnt_s[IDX_CPU];
            resp_wb_r       <= gnt_s[IDX_WB];
            resp_sram_rd_r  <= (gnt_s[IDX_CPU] && cpu_in_range_s && (cpu_mem_wstrb == 4'b0000)) ||
                               (gnt_s[IDX_WB] && wb_in_sram_s && !wbs_we_i);
            resp_reg_data_r <= (gnt_s[IDX_WB] && wb_is_ctrl_s && !wbs_we_i) ?
                               ctrl_word(run_r, err_r, 8'(ADDR_W)) : 32'h0000_0000;
        end
    end

    // Control register; an error set in the same cycle as a clear wins
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            run_r        <= 1'b0;
            err_r        <= 1'b0;
            cpu_resetn_r <= 1'b0;
        end else begin
            cpu_resetn_r <= run_r;
            if (ctrl_wr_s) begin
                run_r <= wbs_dat_i[CTRL_RUN_BIT];
            end else begin
                run_r <= run_r;
            end
            if (cpu_oor_s) begin
                err_r <= 1'b1;
            end else if (ctrl_wr_s && wbs_dat_i[CTRL_ERR_BIT]) begin
                err_r <= 1'b0;
            end else begin
                err_r <= err_r;
            end
        end
    end

    // Response drive; a reset arriving during RESP swallows the response
    always_comb begin
        wbs_ack_o     = 1'b0;
        wbs_dat_o     = 32'h0000_0000;
        cpu_mem_ready = 1'b0;
        cpu_mem_rdata = 32'h0000_0000;
        if ((state_r == ST_RESP) && !wb_rst_i) begin
            if (resp_wb_r) begin
                wbs_ack_o = 1'b1;
                wbs_dat_o = resp_sram_rd_r ? ram_do0 : resp_reg_data_r;
            end else if (resp_cpu_r) begin
                cpu_mem_ready = 1'b1;
                cpu_mem_rdata = resp_sram_rd_r ? ram_do0 : 32'h0000_0000;
            end else begin
                wbs_ack_o = 1'b0;
            end
        end else begin
            wbs_ack_o = 1'b0;
        end
    end

    assign cpu_resetn = cpu_resetn_r;

endmodule

// File: tb/tb_picorv32_sram_ctrl.sv
// Self-checking bench for picorv32_sram_ctrl: directed scenarios plus a
// randomized mix of Wishbone and CPU accesses checked against a
// transaction-level model (memory array, run/err flags, last-served flag).
module tb_picorv32_sram_ctrl;

    localparam logic [31:0] BASE  = 32'h3000_0000;
    localparam logic [31:0] CTRLA = 32'h3001_0000;
    localparam int          WORDS = 512;

    logic        clk = 1'b0;
    logic        wb_rst_i, wbs_stb_i, wbs_cyc_i, wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_i, wbs_adr_i, wbs_dat_o;
    logic        wbs_ack_o;
    logic        cpu_mem_valid, cpu_mem_ready, cpu_resetn;
    logic [31:0] cpu_mem_addr, cpu_mem_wdata, cpu_mem_rdata;
    logic [3:0]  cpu_mem_wstrb;
    logic        ram_en0;
    logic [3:0]  ram_we0;
    logic [8:0]  ram_a0;
    logic [31:0] ram_di0, ram_do0;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] sram    [0:WORDS-1];
    logic [31:0] ref_mem [0:WORDS-1];
    bit ref_run, ref_err, ref_last_wb;

    always #5 clk = ~clk;

    picorv32_sram_ctrl dut (
        .wb_clk_i(clk), .wb_rst_i(wb_rst_i),
        .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_dat_i(wbs_dat_i), .wbs_adr_i(wbs_adr_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .cpu_mem_valid(cpu_mem_valid), .cpu_mem_addr(cpu_mem_addr),
        .cpu_mem_wdata(cpu_mem_wdata), .cpu_mem_wstrb(cpu_mem_wstrb),
        .cpu_mem_ready(cpu_mem_ready), .cpu_mem_rdata(cpu_mem_rdata),
        .cpu_resetn(cpu_resetn),
        .ram_en0(ram_en0), .ram_we0(ram_we0), .ram_a0(ram_a0),
        .ram_di0(ram_di0), .ram_do0(ram_do0)
    );

    // SRAM device: byte-write, one-cycle read latency, read returns the old word
    always @(posedge clk) begin
        if (ram_en0) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_we0[b]) sram[ram_a0][8*b +: 8] <= ram_di0[8*b +: 8];
            end
            ram_do0 <= sram[ram_a0];
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] exp_ctrl();
        return {8'h00, 8'd9, 14'd0, ref_err, ref_run};
    endfunction

    function automatic logic [31:0] model_wb(input logic [31:0] adr, input logic we,
                                             input logic [3:0] sel, input logic [31:0] dat);
        logic [31:0] r;
        int idx;
        r = 32'h0;
        if (adr >= BASE && adr < BASE + 32'd2048) begin
            idx = int'((adr - BASE) / 32'd4);
            if (we) begin
                for (int b = 0; b < 4; b++)
                    if (sel[b]) ref_mem[idx][8*b +: 8] = dat[8*b +: 8];
            end else begin
                r = ref_mem[idx];
            end
        end else if ((adr >> 2) == (CTRLA >> 2)) begin
            if (we) begin
                if (sel[0]) begin
                    ref_run = dat[0];
                    if (dat[1]) ref_err = 1'b0;
                end
            end else begin
                r = exp_ctrl();
            end
        end
        ref_last_wb = 1'b1;
        return r;
    endfunction

    function automatic logic [31:0] model_cpu(input logic [31:0] addr, input logic [3:0] strb,
                                              input logic [31:0] wd, output bit responds);
        logic [31:0] r;
        r = 32'h0;
        responds = ref_run;
        if (!ref_run) return r;
        if (addr < 32'd2048) begin
            if (strb != 4'b0000) begin
                for (int b = 0; b < 4; b++)
                    if (strb[b]) ref_mem[addr/4][8*b +: 8] = wd[8*b +: 8];
            end else begin
                r = ref_mem[addr/4];
            end
        end else begin
            ref_err = 1'b1;
        end
        ref_last_wb = 1'b0;
        return r;
    endfunction

    // ---------------- bus drivers ----------------
    task automatic wb_xfer(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                           input logic [31:0] dat, output logic [31:0] rd, output int lat,
                           output bit got, output bit en_seen);
        @(posedge clk); #1;
        wbs_adr_i = adr; wbs_we_i = we; wbs_sel_i = sel; wbs_dat_i = dat;
        wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1;
        #1 en_seen = ram_en0;
        got = 1'b0; lat = 0; rd = 32'h0;
        while (!got && lat < 8) begin
            @(posedge clk); #1;
            lat = lat + 1;
            if (wbs_ack_o) begin got = 1'b1; rd = wbs_dat_o; end
        end
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
    endtask

    task automatic cpu_xfer(input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] wd,
                            output logic [31:0] rd, output int lat, output bit got, output bit en_seen);
        @(posedge clk); #1;
        cpu_mem_addr = addr; cpu_mem_wstrb = strb; cpu_mem_wdata = wd; cpu_mem_valid = 1'b1;
        #1 en_seen = ram_en0;
        got = 1'b0; lat = 0; rd = 32'h0;
        while (!got && lat < 8) begin
            @(posedge clk); #1;
            lat = lat + 1;
            if (cpu_mem_ready) begin got = 1'b1; rd = cpu_mem_rdata; end
        end
        cpu_mem_valid = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [31:0] rd; int lat; bit got, en;
        wb_rst_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if ({wbs_ack_o, cpu_mem_ready, ram_en0, ram_we0, cpu_resetn} !== 8'h00) begin
            n_err++; $display("FAIL reset_outputs: got %b required 0", {wbs_ack_o, cpu_mem_ready, ram_en0, ram_we0, cpu_resetn}); end
        n_vec++; if ({wbs_dat_o, cpu_mem_rdata} !== 64'h0) begin
            n_err++; $display("FAIL reset_data: got %h required 0", {wbs_dat_o, cpu_mem_rdata}); end
        wb_rst_i = 1'b0;
        ref_run = 1'b0; ref_err = 1'b0; ref_last_wb = 1'b0;
        wb_xfer(CTRLA, 1'b0, 4'hF, 32'h0, rd, lat, got, en);
        n_vec++; if (!got || lat != 1) begin n_err++; $display("FAIL reset_ctrl_lat: got %0d required 1", lat); end
        n_vec++; if (rd !== model_wb(CTRLA, 1'b0, 4'hF, 32'h0)) begin
            n_err++; $display("FAIL reset_ctrl_value: got %h required %h", rd, exp_ctrl()); end
    endtask

    task automatic test_run_enable();
        logic [31:0] rd; int lat; bit got, en;
        wb_xfer(CTRLA, 1'b1, 4'b0001, 32'h1, rd, lat, got, en);
        void'(model_wb(CTRLA, 1'b1, 4'b0001, 32'h1));
        n_vec++; if (!got || lat != 1) begin n_err++; $display("FAIL run_ack_lat: got %0d required 1", lat); end
        n_vec++; if (cpu_resetn !== 1'b0) begin n_err++; $display("FAIL run_resetn_early: got %b required 0", cpu_resetn); end
        @(posedge clk); #1;
        n_vec++; if (cpu_resetn !== ref_run) begin n_err++; $display("FAIL run_resetn: got %b required %b", cpu_resetn, ref_run); end
    endtask

    task automatic test_partial_write();
        logic [31:0] rd, exp; int lat; bit got, en, resp;
        wb_xfer(BASE + 32'd8, 1'b1, 4'b0011, 32'hDEAD_BEEF, rd, lat, got, en);
        void'(model_wb(BASE + 32'd8, 1'b1, 4'b0011, 32'hDEAD_BEEF));
        n_vec++; if (!got || !en) begin n_err++; $display("FAIL pw_wb_write: ack %b en %b required 1 1", got, en); end
        cpu_xfer(32'd8, 4'b0000, 32'h0, rd, lat, got, en);
        exp = model_cpu(32'd8, 4'b0000, 32'h0, resp);
        n_vec++; if (got != resp || lat != 1) begin n_err++; $display("FAIL pw_cpu_lat: got %0d required 1", lat); end
        n_vec++; if (rd !== exp) begin n_err++; $display("FAIL pw_cpu_data: got %h required %h", rd, exp); end
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 2; r++) begin
            logic [31:0] wa, cb, wd, exp_cpu, got_cpu;
            bit exp_first_wb, both_hi, wb_p, cpu_p, dummy;
            int order[$];
            int cyc;
            wa = 32'($urandom_range(0, 15)); cb = 32'(16 + $urandom_range(0, 15)); wd = $urandom;
            exp_first_wb = !ref_last_wb;
            if (exp_first_wb) begin
                void'(model_wb(BASE + wa * 4, 1'b1, 4'hF, wd));
                exp_cpu = model_cpu(cb * 4, 4'b0000, 32'h0, dummy);
            end else begin
                exp_cpu = model_cpu(cb * 4, 4'b0000, 32'h0, dummy);
                void'(model_wb(BASE + wa * 4, 1'b1, 4'hF, wd));
            end
            @(posedge clk); #1;
            wbs_adr_i = BASE + wa * 4; wbs_we_i = 1'b1; wbs_sel_i = 4'hF; wbs_dat_i = wd;
            wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1;
            cpu_mem_addr = cb * 4; cpu_mem_wstrb = 4'b0000; cpu_mem_wdata = 32'h0; cpu_mem_valid = 1'b1;
            wb_p = 1'b1; cpu_p = 1'b1; both_hi = 1'b0; got_cpu = 32'hX; cyc = 0;
            while ((wb_p || cpu_p) && cyc < 12) begin
                @(posedge clk); #1;
                cyc++;
                if (wbs_ack_o && cpu_mem_ready) both_hi = 1'b1;
                if (wbs_ack_o && wb_p) begin
                    order.push_back(1); wb_p = 1'b0; wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
                end
                if (cpu_mem_ready && cpu_p) begin
                    order.push_back(0); cpu_p = 1'b0; got_cpu = cpu_mem_rdata; cpu_mem_valid = 1'b0;
                end
            end
            wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; cpu_mem_valid = 1'b0;
            n_vec++; if (order.size() != 2) begin n_err++; $display("FAIL b2b_count: got %0d required 2", order.size()); end
            else begin
                n_vec++; if (order[0] != int'(exp_first_wb)) begin
                    n_err++; $display("FAIL b2b_first: got wb=%0d required wb=%0d", order[0], exp_first_wb); end
                n_vec++; if (order[1] == order[0]) begin n_err++; $display("FAIL b2b_second: got wb=%0d twice", order[0]); end
            end
            n_vec++; if (both_hi) begin n_err++; $display("FAIL b2b_overlap: got both responses in one cycle required one"); end
            n_vec++; if (got_cpu !== exp_cpu) begin n_err++; $display("FAIL b2b_cpu_data: got %h required %h", got_cpu, exp_cpu); end
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] rd, exp; int lat; bit got, en, resp;
        cpu_xfer(32'h0000_0800, 4'b0000, 32'h0, rd, lat, got, en);
        exp = model_cpu(32'h0000_0800, 4'b0000, 32'h0, resp);
        n_vec++; if (got != resp || lat != 1) begin n_err++; $display("FAIL oor_ready: got %b lat %0d required 1 1", got, lat); end
        n_vec++; if (rd !== exp) begin n_err++; $display("FAIL oor_rdata: got %h required %h", rd, exp); end
        n_vec++; if (en) begin n_err++; $display("FAIL oor_ram_en: got 1 required 0"); end
        // stop the core while keeping err, then read the register back
        wb_xfer(CTRLA, 1'b1, 4'b0001, 32'h0, rd, lat, got, en);
        void'(model_wb(CTRLA, 1'b1, 4'b0001, 32'h0));
        wb_xfer(CTRLA, 1'b0, 4'hF, 32'h0, rd, lat, got, en);
        exp = model_wb(CTRLA, 1'b0, 4'hF, 32'h0);
        n_vec++; if (rd !== exp) begin n_err++; $display("FAIL oor_ctrl: got %h required %h", rd, exp); end
        // with run low the CPU request must be ignored
        cpu_xfer(32'h0000_0010, 4'b0000, 32'h0, rd, lat, got, en);
        exp = model_cpu(32'h0000_0010, 4'b0000, 32'h0, resp);
        n_vec++; if (got != resp) begin n_err++; $display("FAIL stopped_cpu: got ready %b required %b", got, resp); end
        // a byte-1-only write must not touch run or err
        wb_xfer(CTRLA, 1'b1, 4'b0010, 32'h3, rd, lat, got, en);
        void'(model_wb(CTRLA, 1'b1, 4'b0010, 32'h3));
        // restart and clear err together
        wb_xfer(CTRLA, 1'b1, 4'b0001, 32'h3, rd, lat, got, en);
        void'(model_wb(CTRLA, 1'b1, 4'b0001, 32'h3));
        wb_xfer(CTRLA, 1'b0, 4'hF, 32'h0, rd, lat, got, en);
        exp = model_wb(CTRLA, 1'b0, 4'hF, 32'h0);
        n_vec++; if (rd !== exp) begin n_err++; $display("FAIL ctrl_clear: got %h required %h", rd, exp); end
    endtask

    task automatic test_unmapped();
        logic [31:0] rd, exp; int lat; bit got, en;
        wb_xfer(BASE + 32'h0002_0000, 1'b0, 4'hF, 32'h0, rd, lat, got, en);
        exp = model_wb(BASE + 32'h0002_0000, 1'b0, 4'hF, 32'h0);
        n_vec++; if (!got || lat != 1) begin n_err++; $display("FAIL unm_ack: got %b lat %0d required 1 1", got, lat); end
        n_vec++; if (rd !== exp) begin n_err++; $display("FAIL unm_dat: got %h required %h", rd, exp); end
        n_vec++; if (en) begin n_err++; $display("FAIL unm_ram_en: got 1 required 0"); end
        wb_xfer(BASE + 32'h0002_0000, 1'b1, 4'hF, 32'hFFFF_FFFF, rd, lat, got, en);
        void'(model_wb(BASE + 32'h0002_0000, 1'b1, 4'hF, 32'hFFFF_FFFF));
        n_vec++; if (en) begin n_err++; $display("FAIL unm_wr_ram_en: got 1 required 0"); end
        wb_xfer(CTRLA, 1'b0, 4'hF, 32'h0, rd, lat, got, en);
        exp = model_wb(CTRLA, 1'b0, 4'hF, 32'h0);
        n_vec++; if (rd !== exp) begin n_err++; $display("FAIL unm_ctrl: got %h required %h", rd, exp); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 80; i++) begin
            logic [31:0] rd, exp, adr, wd; logic [3:0] sel; int lat; bit got, en, resp; int op;
            op  = int'($urandom_range(0, 4));
            wd  = $urandom;
            sel = 4'($urandom_range(1, 15));
            adr = 32'($urandom_range(0, 15)) * 4;
            case (op)
                0: begin wb_xfer(BASE + adr, 1'b1, sel, wd, rd, lat, got, en); exp = model_wb(BASE + adr, 1'b1, sel, wd); end
                1: begin wb_xfer(BASE + adr, 1'b0, 4'hF, 32'h0, rd, lat, got, en); exp = model_wb(BASE + adr, 1'b0, 4'hF, 32'h0); end
                2: begin
                    sel = 4'($urandom_range(0, 15));
                    cpu_xfer(adr, sel, wd, rd, lat, got, en); exp = model_cpu(adr, sel, wd, resp);
                end
                3: begin cpu_xfer(32'h0001_0000 + adr, 4'b0000, wd, rd, lat, got, en); exp = model_cpu(32'h0001_0000 + adr, 4'b0000, wd, resp); end
                default: begin wb_xfer(CTRLA, 1'b0, 4'hF, 32'h0, rd, lat, got, en); exp = model_wb(CTRLA, 1'b0, 4'hF, 32'h0); end
            endcase
            n_vec++; if (!got || lat != 1) begin n_err++; $display("FAIL rnd_lat[%0d] op%0d: got %b/%0d required 1/1", i, op, got, lat); end
            n_vec++; if (rd !== exp) begin n_err++; $display("FAIL rnd_data[%0d] op%0d: got %h required %h", i, op, rd, exp); end
        end
    endtask

    task automatic test_reset_in_resp();
        logic [31:0] rd, exp; int lat; bit got, en, resp, seen;
        cpu_xfer(32'h0000_0900, 4'b0000, 32'h0, rd, lat, got, en);   // sets err first
        void'(model_cpu(32'h0000_0900, 4'b0000, 32'h0, resp));
        @(posedge clk); #1;
        cpu_mem_addr = 32'd4; cpu_mem_wstrb = 4'b0000; cpu_mem_valid = 1'b1;
        @(posedge clk); #1;
        wb_rst_i = 1'b1;
        #1;
        seen = cpu_mem_ready;
        @(posedge clk); #1;
        wb_rst_i = 1'b0;
        ref_run = 1'b0; ref_err = 1'b0; ref_last_wb = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (cpu_mem_ready) seen = 1'b1;
        end
        cpu_mem_valid = 1'b0;
        n_vec++; if (seen) begin n_err++; $display("FAIL rst_resp_ready: got 1 required 0"); end
        n_vec++; if (cpu_resetn !== ref_run) begin n_err++; $display("FAIL rst_resp_resetn: got %b required %b", cpu_resetn, ref_run); end
        wb_xfer(CTRLA, 1'b0, 4'hF, 32'h0, rd, lat, got, en);
        exp = model_wb(CTRLA, 1'b0, 4'hF, 32'h0);
        n_vec++; if (rd !== exp) begin n_err++; $display("FAIL rst_resp_ctrl: got %h required %h", rd, exp); end
    endtask

    initial begin
        wb_rst_i = 1'b1; wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
        wbs_sel_i = 4'h0; wbs_dat_i = 32'h0; wbs_adr_i = 32'h0;
        cpu_mem_valid = 1'b0; cpu_mem_addr = 32'h0; cpu_mem_wdata = 32'h0; cpu_mem_wstrb = 4'h0;
        for (int i = 0; i < WORDS; i++) begin sram[i] = 32'h0; ref_mem[i] = 32'h0; end
        test_reset();
        test_run_enable();
        test_partial_write();
        test_back_to_back();
        test_out_of_range();
        test_unmapped();
        test_random();
        test_reset_in_resp();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
